// File: rtl/alu_arbiter_pkg.sv
// alu_arbiter_pkg: opcodes, FSM state encoding and default settle time shared by
//   the alu_arbiter block and its bench-facing users.
package alu_arbiter_pkg;

    localparam logic [2:0] OP_ADD  = 3'b000;
    localparam logic [2:0] OP_SUB  = 3'b001;
    localparam logic [2:0] OP_XOR  = 3'b010;
    localparam logic [2:0] OP_SLT  = 3'b011;
    localparam logic [2:0] OP_NAND = 3'b100;
    localparam logic [2:0] OP_NOR  = 3'b101;
    localparam logic [2:0] OP_XNOR = 3'b110;
    localparam logic [2:0] OP_RSV  = 3'b111;

    localparam int SETTLE_DEFAULT = 4;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_e;

    // Only the arithmetic ops produce meaningful carry/overflow flags.
    function automatic logic has_flags(input logic [2:0] op);
        return (op == OP_ADD) || (op == OP_SUB);
    endfunction

endpackage

// File: rtl/alu_arbiter_rr.sv
// rr_arbiter2: two-way round-robin grant; the pointer moves past the winner on accept.
//   req       - request vector (bit i = requester i)
//   accept    - grant is being taken this cycle, advance the pointer
//   grant     - one-hot grant (0 when no request)
//   grant_idx - index of the granted requester
module rr_arbiter2 (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] req,
    input  logic       accept,
    output logic [1:0] grant,
    output logic       grant_idx
);

    // prio_q names the requester that wins a tie; 0 after reset.
    logic prio_q, prio_d;

    always_comb begin
        grant_idx = (&req) ? prio_q : req[1];
        grant     = (|req) ? (grant_idx ? 2'b10 : 2'b01) : 2'b00;
        prio_d    = accept ? ~grant_idx : prio_q;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) prio_q <= 1'b0;
        else       prio_q <= prio_d;
    end

endmodule

// File: rtl/alu_arbiter.sv
// alu_arbiter: shares one external combinational ALU between two requesters,
//   one operation in flight, holding operands SETTLE cycles before sampling.
//   req_*   - per-requester valid/ready/op/a/b (requester i in slice i)
//   alu_*   - operands to and results from the shared ALU
//   rsp_*   - one-hot valid, per-requester ready, registered result and flags
module alu_arbiter
    import alu_arbiter_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int SETTLE = SETTLE_DEFAULT
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [1:0]         req_valid,
    output logic [1:0]         req_ready,
    input  logic [5:0]         req_op,
    input  logic [2*WIDTH-1:0] req_a,
    input  logic [2*WIDTH-1:0] req_b,
    output logic [2:0]         alu_op,
    output logic [WIDTH-1:0]   alu_a,
    output logic [WIDTH-1:0]   alu_b,
    input  logic [WIDTH-1:0]   alu_result,
    input  logic               alu_carryout,
    input  logic               alu_overflow,
    output logic [1:0]         rsp_valid,
    input  logic [1:0]         rsp_ready,
    output logic [WIDTH-1:0]   rsp_result,
    output logic               rsp_carryout,
    output logic               rsp_overflow,
    output logic               rsp_error
);

    localparam int CW = (SETTLE > 1) ? $clog2(SETTLE) : 1;

    state_e           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             owner_q, owner_d;
    logic [2:0]       op_q, op_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic             carry_q, carry_d, ovf_q, ovf_d, err_q, err_d;

    logic [1:0]       grant;
    logic             grant_idx;
    logic             accept;
    logic [2:0]       sel_op;
    logic [WIDTH-1:0] sel_a, sel_b;

    // Only IDLE accepts, so a response handshake never overlaps a new accept.
    assign accept = (state_q == S_IDLE) && (|req_valid);
    assign sel_op = grant_idx ? req_op[5:3] : req_op[2:0];
    assign sel_a  = grant_idx ? req_a[2*WIDTH-1:WIDTH] : req_a[WIDTH-1:0];
    assign sel_b  = grant_idx ? req_b[2*WIDTH-1:WIDTH] : req_b[WIDTH-1:0];

    rr_arbiter2 u_rr (
        .clk       (clk),
        .reset     (reset),
        .req       (req_valid),
        .accept    (accept),
        .grant     (grant),
        .grant_idx (grant_idx)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            owner_q <= 1'b0;
            op_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            carry_q <= 1'b0;
            ovf_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            owner_q <= owner_d;
            op_q    <= op_d;
            a_q     <= a_d;
            b_q     <= b_d;
            res_q   <= res_d;
            carry_q <= carry_d;
            ovf_q   <= ovf_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  state_d = accept ? ((sel_op == OP_RSV) ? S_RESP : S_WAIT) : S_IDLE;
            S_WAIT:  state_d = (cnt_q == '0) ? S_RESP : S_WAIT;
            S_RESP:  state_d = rsp_ready[owner_q] ? S_IDLE : S_RESP;
            default: state_d = S_IDLE;
        endcase
    end

    // Capture on accept; the counter starts at SETTLE-1 so WAIT spans SETTLE cycles
    // and the ALU outputs are registered on the edge that ends the last one.
    always_comb begin
        cnt_d   = cnt_q;
        owner_d = owner_q;
        op_d    = op_q;
        a_d     = a_q;
        b_d     = b_q;
        res_d   = res_q;
        carry_d = carry_q;
        ovf_d   = ovf_q;
        err_d   = err_q;
        if (accept) begin
            owner_d = grant_idx;
            op_d    = sel_op;
            a_d     = sel_a;
            b_d     = sel_b;
            cnt_d   = CW'(SETTLE - 1);
            if (sel_op == OP_RSV) begin
                res_d   = '0;
                carry_d = 1'b0;
                ovf_d   = 1'b0;
                err_d   = 1'b1;
            end
        end else if (state_q == S_WAIT) begin
            cnt_d = (cnt_q == '0) ? '0 : cnt_q - CW'(1);
            if (cnt_q == '0) begin
                res_d   = alu_result;
                carry_d = has_flags(op_q) & alu_carryout;
                ovf_d   = has_flags(op_q) & alu_overflow;
                err_d   = 1'b0;
            end
        end
    end

    always_comb begin
        req_ready = accept ? grant : 2'b00;
        rsp_valid = (state_q == S_RESP) ? (owner_q ? 2'b10 : 2'b01) : 2'b00;
    end

    assign alu_op       = op_q;
    assign alu_a        = a_q;
    assign alu_b        = b_q;
    assign rsp_result   = res_q;
    assign rsp_carryout = carry_q;
    assign rsp_overflow = ovf_q;
    assign rsp_error    = err_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: randomized and directed checks of alu_arbiter against a transaction-level model.
module tb_alu_arbiter;

    localparam int W  = 32;
    localparam int ST = 4;

    logic           clk = 1'b0;
    logic           reset = 1'b1;
    logic [1:0]     req_valid = '0;
    logic [1:0]     req_ready;
    logic [5:0]     req_op = '0;
    logic [2*W-1:0] req_a = '0;
    logic [2*W-1:0] req_b = '0;
    logic [2:0]     alu_op;
    logic [W-1:0]   alu_a, alu_b, alu_result;
    logic           alu_carryout, alu_overflow;
    logic [1:0]     rsp_valid;
    logic [1:0]     rsp_ready = '0;
    logic [W-1:0]   rsp_result;
    logic           rsp_carryout, rsp_overflow, rsp_error;

    int errs = 0;
    int checks = 0;
    logic last_g = 1'b1;
    logic [W-1:0] last_res;
    logic last_c, last_v, last_e, last_w;

    alu_arbiter #(.WIDTH(W), .SETTLE(ST)) dut (
        .clk          (clk),
        .reset        (reset),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_op       (req_op),
        .req_a        (req_a),
        .req_b        (req_b),
        .alu_op       (alu_op),
        .alu_a        (alu_a),
        .alu_b        (alu_b),
        .alu_result   (alu_result),
        .alu_carryout (alu_carryout),
        .alu_overflow (alu_overflow),
        .rsp_valid    (rsp_valid),
        .rsp_ready    (rsp_ready),
        .rsp_result   (rsp_result),
        .rsp_carryout (rsp_carryout),
        .rsp_overflow (rsp_overflow),
        .rsp_error    (rsp_error)
    );

    always #5 clk = ~clk;

    // Returns {overflow, carry, result} as a requester expects to see them.
    function automatic logic [W+1:0] ref_alu(input logic [2:0] op, input logic [W-1:0] a, b);
        logic [W:0] s;
        logic [W-1:0] r;
        logic c, v;
        c = 1'b0; v = 1'b0; r = '0; s = '0;
        case (op)
            3'd0: begin s = {1'b0, a} + {1'b0, b}; r = s[W-1:0]; c = s[W];
                        v = (a[W-1] == b[W-1]) && (r[W-1] != a[W-1]); end
            3'd1: begin s = {1'b0, a} + {1'b0, ~b} + 33'd1; r = s[W-1:0]; c = s[W];
                        v = (a[W-1] != b[W-1]) && (r[W-1] != a[W-1]); end
            3'd2: r = a ^ b;
            3'd3: r = ($signed(a) < $signed(b)) ? 1 : 0;
            3'd4: r = ~(a & b);
            3'd5: r = ~(a | b);
            3'd6: r = ~(a ^ b);
            default: r = '0;
        endcase
        return {v, c, r};
    endfunction

    // Shared ALU stand-in: logic ops drive junk flags and op 7 junk data,
    // which the arbiter has to mask.
    logic [W+1:0] ext;
    always_comb begin
        ext          = ref_alu(alu_op, alu_a, alu_b);
        alu_result   = (alu_op == 3'd7) ? (alu_a ^ 32'hDEADBEEF) : ext[W-1:0];
        alu_carryout = (alu_op < 3'd2) ? ext[W] : ~alu_a[0];
        alu_overflow = (alu_op < 3'd2) ? ext[W+1] : alu_b[0];
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic check_zero_outputs(input string tag);
        check({tag, "_req_ready"}, req_ready, 0);
        check({tag, "_rsp_valid"}, rsp_valid, 0);
        check({tag, "_alu_op"}, alu_op, 0);
        check({tag, "_alu_a"}, alu_a, 0);
        check({tag, "_alu_b"}, alu_b, 0);
        check({tag, "_rsp_flags"}, {rsp_carryout, rsp_overflow, rsp_error}, 0);
        check({tag, "_rsp_result"}, rsp_result, 0);
    endtask

    // Starts just after a falling edge; ends just after a falling edge in IDLE.
    task automatic run_op(input logic [1:0] v, input logic [2:0] op0, op1,
                          input logic [W-1:0] a0, b0, a1, b1, input int hold);
        logic w;
        logic [2:0] op;
        logic [W+1:0] e;
        int n, lat;
        req_valid = v; req_op = {op1, op0}; req_a = {a1, a0}; req_b = {b1, b0}; rsp_ready = '0;
        w   = (v == 2'b11) ? ~last_g : v[1];
        op  = w ? op1 : op0;
        e   = w ? ref_alu(op1, a1, b1) : ref_alu(op0, a0, b0);
        lat = (op == 3'd7) ? 1 : ST + 1;
        last_w = w;
        #1 check("req_ready", req_ready, w ? 2'b10 : 2'b01);
        @(posedge clk);
        last_g = w;
        @(negedge clk);
        req_valid[w] = 1'b0;
        n = 1;
        while (rsp_valid == 2'b00 && n <= lat + 20) begin
            #1 check("ready_busy", req_ready, 0);
            check("alu_op", alu_op, op);
            check("alu_ab", {alu_a, alu_b}, w ? {a1, b1} : {a0, b0});
            @(negedge clk);
            n++;
        end
        check("latency", n, lat);
        if (rsp_valid == 2'b00) return;
        #1 check("rsp_valid", rsp_valid, w ? 2'b10 : 2'b01);
        check("rsp_result", rsp_result, e[W-1:0]);
        check("rsp_flags", {rsp_overflow, rsp_carryout}, e[W+1:W]);
        check("rsp_error", rsp_error, op == 3'd7);
        last_res = rsp_result; last_c = rsp_carryout; last_v = rsp_overflow; last_e = rsp_error;
        rsp_ready[~w] = 1'b1;
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            #1 check("hold_valid", rsp_valid, w ? 2'b10 : 2'b01);
            check("hold_rsp", {rsp_result, rsp_overflow, rsp_carryout, rsp_error},
                  {e[W-1:0], e[W+1:W], op == 3'd7});
            check("hold_ready", req_ready, 0);
        end
        rsp_ready = w ? 2'b10 : 2'b01;
        #1 check("hs_ready", req_ready, 0);
        @(negedge clk);
        rsp_ready = '0;
        req_valid = '0;
        #1 check("post_hs_valid", rsp_valid, 0);
    endtask

    function automatic logic [W-1:0] rnd_val();
        case ($urandom_range(0, 5))
            0: return '0;
            1: return '1;
            2: return 32'h7FFFFFFF;
            3: return 32'h80000000;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        repeat (2) @(negedge clk);
        #1 check_zero_outputs("reset");
        reset = 1'b0;
        @(negedge clk);

        // Both valid from reset: SUB then XOR, then alternation continues.
        run_op(2'b11, 3'd1, 3'd2, 5, 3, 32'hF0, 32'h0F, 10);
        check("sub_winner", last_w, 0);
        check("sub_res", {last_res, last_c}, {32'd2, 1'b1});
        run_op(2'b11, 3'd1, 3'd2, 5, 3, 32'hF0, 32'h0F, 0);
        check("xor_winner", last_w, 1);
        check("xor_res", {last_res, last_c}, {32'hFF, 1'b0});
        run_op(2'b11, 3'd0, 3'd6, 1, 2, 3, 4, 1);
        check("alt_2", last_w, 0);
        run_op(2'b11, 3'd0, 3'd6, 1, 2, 3, 4, 1);
        check("alt_3", last_w, 1);

        run_op(2'b01, 3'd0, 3'd0, 32'h7FFFFFFF, 1, 0, 0, 0);
        check("add_ovf", {last_res, last_v, last_c}, {32'h80000000, 1'b1, 1'b0});

        run_op(2'b10, 3'd0, 3'd7, 0, 0, 32'h1234, 32'h5678, 2);
        check("rsv", {last_res, last_e}, {32'd0, 1'b1});

        // Reset in the middle of WAIT after requester 0 was served.
        req_valid = 2'b01; req_op = 6'd0; req_a = {32'd0, 32'd9}; req_b = {32'd0, 32'd9};
        @(posedge clk);
        @(negedge clk);
        req_valid = '0;
        @(negedge clk);
        reset = 1'b1;
        #1 check_zero_outputs("mid_reset");
        @(posedge clk);
        #1 check_zero_outputs("mid_reset_edge");
        @(negedge clk);
        reset = 1'b0;
        last_g = 1'b1;
        for (int i = 0; i < ST + 3; i++) begin
            @(negedge clk);
            #1 check("no_rsp_after_reset", rsp_valid, 0);
        end
        @(negedge clk);
        run_op(2'b11, 3'd2, 3'd2, 1, 1, 2, 2, 0);
        check("grant_after_reset", last_w, 0);

        for (int k = 0; k < 40; k++) begin
            run_op(2'($urandom_range(1, 3)), 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
                   rnd_val(), rnd_val(), rnd_val(), rnd_val(), $urandom_range(0, 3));
        end

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 Parameter WIDTH, default 32: operand/result width in bits.
REQ-002 Parameter SETTLE, default 4: cycles the shared ALU is held stable before its outputs are sampled (covers gate-delay settling, >=1).
REQ-003 Port clk  input  1  single clock; all state updates on rising edge.
REQ-004 Port reset  input  1  asynchronous, active-high reset.
REQ-005 Port req_valid  input  2  per-requester request valid (bit i = requester i).
REQ-006 Port req_ready  output  2  per-requester accept strobe.
REQ-007 Port req_op  input  6  opcodes, requester i at bits [3i+2:3i].
REQ-008 Port req_a  input  2*WIDTH  operand A, requester i at [WIDTH*i+WIDTH-1:WIDTH*i].
REQ-009 Port req_b  input  2*WIDTH  operand B, same packing.
REQ-010 Port alu_op  output  3  opcode to shared ALU.
REQ-011 Port alu_a  output  WIDTH  operand A to shared ALU.
REQ-012 Port alu_b  output  WIDTH  operand B to shared ALU.
REQ-013 Port alu_result  input  WIDTH  shared ALU result.
REQ-014 Port alu_carryout  input  1  shared ALU carry out.
REQ-015 Port alu_overflow  input  1  shared ALU overflow.
REQ-016 Port rsp_valid  output  2  one-hot response valid, bit = owning requester.
REQ-017 Port rsp_ready  input  2  per-requester response accept.
REQ-018 Port rsp_result  output  WIDTH  registered result.
REQ-019 Port rsp_carryout  output  1  registered carry out.
REQ-020 Port rsp_overflow  output  1  registered overflow.
REQ-021 Port rsp_error  output  1  set when the served opcode was reserved.

Function
REQ-022 Opcodes SHALL be: 000 ADD, 001 SUB, 010 XOR, 011 SLT, 100 NAND, 101 NOR, 110 XNOR, 111 reserved.
REQ-023 FSM states SHALL be IDLE, WAIT, RESP; one operation in flight at a time.
REQ-024 In IDLE with any req_valid set, the arbiter SHALL grant one requester, assert req_ready for that requester only (combinational, same cycle), capture its op/a/b, and move to WAIT.
REQ-025 Arbitration SHALL be round-robin: with both valid, grant the requester not served last; after reset, requester 0 has priority.
REQ-026 req_ready SHALL be 0 outside IDLE; requests arriving in WAIT/RESP wait.
REQ-027 alu_op/alu_a/alu_b SHALL be driven from the capture registers, stable from WAIT entry until RESP exit.
REQ-028 WAIT SHALL last exactly SETTLE cycles (down-counter); on its last cycle, alu_result/carryout/overflow are registered into rsp_* and state goes to RESP.
REQ-029 For opcodes other than ADD/SUB, rsp_carryout and rsp_overflow SHALL be 0.
REQ-030 Reserved opcode 111 SHALL skip WAIT: RESP entered next cycle with rsp_result=0, rsp_error=1, carry/overflow 0.
REQ-031 In RESP, rsp_valid[granted]=1 and rsp_* SHALL hold until rsp_ready[granted]=1; then IDLE next cycle; rsp_ready of the other requester is ignored.
REQ-032 Latency: accept at cycle T -> rsp_valid first high at T+1+SETTLE (T+1 for reserved); peak throughput one op per SETTLE+2 cycles.
REQ-033 A request accepted in the same cycle as nothing else; a response handshake and a new req_valid in the same cycle SHALL NOT accept the new request until the following IDLE cycle.

Reset
REQ-034 Reset SHALL force IDLE, counter 0, round-robin pointer to requester 0, capture registers 0, alu_* 0, rsp_valid 0, rsp_result 0, rsp_carryout 0, rsp_overflow 0, rsp_error 0, req_ready 0.
REQ-035 Reset asserted mid-WAIT or mid-RESP SHALL drop the in-flight operation with no response issued.

Structure
REQ-036 Package alu_arbiter_pkg SHALL hold opcode constants, FSM state encoding and SETTLE default.
REQ-037 Grant logic SHALL be a sub-module rr_arbiter2 (2-way round-robin, pointer update on accept).

Verification
REQ-038 Requester 0 ADD a=32'h7FFFFFFF b=1, SETTLE=4 -> req_ready[0] at T, rsp_valid=2'b01 at T+5, result 32'h80000000, overflow 1, carry 0.
REQ-039 Both valid from reset, ops SUB 5-3 and XOR F0^0F -> requester 0 served first (result 2, carry 1), then requester 1 (result 32'hFF, carry 0).
REQ-040 Both held valid for 4 ops -> grants alternate 0,1,0,1.
REQ-041 Requester 1 op 111 -> rsp_valid=2'b10 at T+1, result 0, rsp_error 1.
REQ-042 rsp_ready held 0 for 10 cycles in RESP -> rsp_* unchanged, req_ready stays 0 despite req_valid.
REQ-043 reset pulsed during WAIT -> all outputs 0 next edge, no rsp_valid, next grant goes to requester 0.
